// File: rtl/pattern_generator.sv
// pattern_generator: valid/ready stream source producing ramp-up, ramp-down,
// triangle or constant sequences from a configuration latched on start.
// valid/ready: a beat transfers on a rising edge where valid && ready; while
// valid && !ready, data and last hold stable; valid only falls after a transfer.
module pattern_generator #(
    parameter int DATA_WIDTH  = 16,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   stop,
    input  logic [1:0]             cfg_mode,
    input  logic [DATA_WIDTH-1:0]  cfg_min,
    input  logic [DATA_WIDTH-1:0]  cfg_max,
    input  logic [DATA_WIDTH-1:0]  cfg_step,
    input  logic [COUNT_WIDTH-1:0] cfg_count,
    output logic                   valid,
    input  logic                   ready,
    output logic [DATA_WIDTH-1:0]  data,
    output logic                   last,
    output logic                   busy,
    output logic                   done,
    output logic                   cfg_err
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                 state, state_n;
    logic [1:0]             mode_q, mode_n;
    logic [DATA_WIDTH-1:0]  min_q, min_n, max_q, max_n, step_q, step_n;
    logic [COUNT_WIDTH-1:0] count_q, count_n, cnt, cnt_n;
    logic [DATA_WIDTH-1:0]  data_n, next_val;
    logic                   dir_up, dir_n, next_dir;
    logic                   stop_pend, stop_pend_n;
    logic                   valid_n, last_n, done_n, cfg_err_n;
    logic                   hs, cfg_bad;

    // Arithmetic one bit wider than the data so sums and bounds never wrap.
    logic [DATA_WIDTH:0]    cur_ext, sum_ext, min_plus, max_ext;
    logic [COUNT_WIDTH:0]   cnt_plus2;

    assign hs        = valid && ready;
    assign busy      = (state == RUN);
    assign cur_ext   = {1'b0, data};
    assign sum_ext   = cur_ext + {1'b0, step_q};
    assign min_plus  = {1'b0, min_q} + {1'b0, step_q};
    assign max_ext   = {1'b0, max_q};
    assign cnt_plus2 = {1'b0, cnt} + (COUNT_WIDTH+1)'(2);
    assign cfg_bad   = (cfg_min > cfg_max) || ((cfg_step == '0) && (cfg_mode != 2'd3));

    // Successor of the current sample and the triangle direction after it.
    always_comb begin
        next_val = min_q;
        next_dir = dir_up;
        case (mode_q)
            2'd0: next_val = (sum_ext > max_ext) ? min_q : sum_ext[DATA_WIDTH-1:0];
            2'd1: next_val = (cur_ext < min_plus) ? max_q : (data - step_q);
            2'd2: begin
                if (dir_up) begin
                    if (sum_ext >= max_ext) begin
                        next_val = max_q;
                        next_dir = 1'b0;
                    end else begin
                        next_val = sum_ext[DATA_WIDTH-1:0];
                    end
                end else begin
                    if (cur_ext <= min_plus) begin
                        next_val = min_q;
                        next_dir = 1'b1;
                    end else begin
                        next_val = data - step_q;
                    end
                end
            end
            default: next_val = min_q;
        endcase
    end

    // Next-state and next-output logic for the IDLE/RUN controller.
    always_comb begin
        state_n     = state;
        mode_n      = mode_q;
        min_n       = min_q;
        max_n       = max_q;
        step_n      = step_q;
        count_n     = count_q;
        cnt_n       = cnt;
        data_n      = data;
        dir_n       = dir_up;
        valid_n     = valid;
        last_n      = last;
        done_n      = 1'b0;
        cfg_err_n   = 1'b0;
        stop_pend_n = stop_pend;
        case (state)
            IDLE: begin
                // A start coinciding with the done pulse is deliberately dropped.
                if (start && !done) begin
                    if (cfg_bad) begin
                        cfg_err_n = 1'b1;
                    end else begin
                        state_n     = RUN;
                        mode_n      = cfg_mode;
                        min_n       = cfg_min;
                        max_n       = cfg_max;
                        step_n      = cfg_step;
                        count_n     = cfg_count;
                        cnt_n       = '0;
                        data_n      = (cfg_mode == 2'd1) ? cfg_max : cfg_min;
                        dir_n       = 1'b1;
                        valid_n     = 1'b1;
                        last_n      = (cfg_count == COUNT_WIDTH'(1));
                        stop_pend_n = 1'b0;
                    end
                end
            end
            RUN: begin
                if (hs) begin
                    cnt_n = cnt + COUNT_WIDTH'(1);
                    if (last || stop || stop_pend) begin
                        state_n     = IDLE;
                        valid_n     = 1'b0;
                        last_n      = 1'b0;
                        done_n      = 1'b1;
                        stop_pend_n = 1'b0;
                    end else begin
                        data_n = next_val;
                        dir_n  = next_dir;
                        last_n = (count_q != '0) && (cnt_plus2 == {1'b0, count_q});
                    end
                end else if (stop) begin
                    stop_pend_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, configuration and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mode_q    <= '0;
            min_q     <= '0;
            max_q     <= '0;
            step_q    <= '0;
            count_q   <= '0;
            cnt       <= '0;
            data      <= '0;
            dir_up    <= 1'b1;
            valid     <= 1'b0;
            last      <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
            stop_pend <= 1'b0;
        end else begin
            state     <= state_n;
            mode_q    <= mode_n;
            min_q     <= min_n;
            max_q     <= max_n;
            step_q    <= step_n;
            count_q   <= count_n;
            cnt       <= cnt_n;
            data      <= data_n;
            dir_up    <= dir_n;
            valid     <= valid_n;
            last      <= last_n;
            done      <= done_n;
            cfg_err   <= cfg_err_n;
            stop_pend <= stop_pend_n;
        end
    end

endmodule

// File: tb/tb_pattern_generator.sv
// Bench for pattern_generator: expected beats queued as {last, data}.
module tb_pattern_generator;

    localparam int DW = 16;
    localparam int CW = 32;
    localparam int W  = DW + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [1:0]    cfg_mode = '0;
    logic [DW-1:0] cfg_min = '0;
    logic [DW-1:0] cfg_max = '0;
    logic [DW-1:0] cfg_step = '0;
    logic [CW-1:0] cfg_count = '0;
    logic          valid;
    logic          ready = 1'b1;
    logic [DW-1:0] data;
    logic          last;
    logic          busy;
    logic          done;
    logic          cfg_err;

    logic [W-1:0]  exp_q[$];
    int            checks = 0;
    int            errors = 0;
    logic          prev_hs = 1'b0;
    logic          prev_done = 1'b0;
    logic          hold_on = 1'b0;
    logic [W-1:0]  hold_val = '0;
    logic          last_seen = 1'b0;

    pattern_generator #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .cfg_mode(cfg_mode), .cfg_min(cfg_min), .cfg_max(cfg_max),
        .cfg_step(cfg_step), .cfg_count(cfg_count), .valid(valid),
        .ready(ready), .data(data), .last(last), .busy(busy),
        .done(done), .cfg_err(cfg_err)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int v, input bit l);
        exp_q.push_back({l, DW'(v)});
    endtask

    // Drive a one-cycle start, then scramble config to prove it is not re-sampled.
    task automatic start_run(input int m, input int mn, input int mx, input int st,
                             input int cn, input bit ok);
        tick();
        cfg_mode  = 2'(m);
        cfg_min   = DW'(mn);
        cfg_max   = DW'(mx);
        cfg_step  = DW'(st);
        cfg_count = CW'(cn);
        start     = 1'b1;
        tick();
        start     = 1'b0;
        cfg_mode  = 2'($urandom_range(0, 3));
        cfg_min   = DW'($urandom_range(0, 65535));
        cfg_max   = DW'($urandom_range(0, 65535));
        cfg_step  = DW'($urandom_range(0, 65535));
        cfg_count = CW'($urandom_range(0, 7));
        @(negedge clk);
        check("first_valid", 32'(valid), 32'(ok));
        check("busy_after_start", 32'(busy), 32'(ok));
        check("cfg_err_after_start", 32'(cfg_err), 32'(!ok));
    endtask

    // rmode: 0 ready held high, 1 toggled, 2 random. poke drives a start into the done cycle.
    task automatic wait_done(input int rmode, input bit poke);
        bit seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                tick();
                case (rmode)
                    1:       ready = ~ready;
                    2:       ready = 1'($urandom_range(0, 1));
                    default: ready = 1'b1;
                endcase
                @(negedge clk);
            end
        end
        check("done_seen", 32'(seen), 32'd1);
        if (poke) begin
            cfg_mode = 2'd0; cfg_min = DW'(1); cfg_max = DW'(9);
            cfg_step = DW'(1); cfg_count = CW'(3);
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("idle_valid", 32'(valid), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        ready = 1'b1;
    endtask

    // scoreboard / monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hs = 1'b0; prev_done = 1'b0; hold_on = 1'b0;
        end else begin
            if (hold_on && valid) check("hold_stable", 32'({last, data}), 32'(hold_val));
            if (valid && ready) begin
                if (exp_q.size() == 0) check("extra_beat", 32'(exp_q.size()), 32'd1);
                else check("beat", 32'({last, data}), 32'(exp_q.pop_front()));
            end
            if (valid && last) last_seen = 1'b1;
            if (done) begin
                check("done_after_handshake", 32'(prev_hs), 32'd1);
                check("done_single", 32'(prev_done), 32'd0);
            end
            hold_on   = valid && !ready;
            hold_val  = {last, data};
            prev_hs   = valid && ready;
            prev_done = done;
        end
    end

    initial begin
        int t1[6] = '{0, 3, 6, 9, 0, 3};
        int t3[9] = '{0, 3, 6, 8, 5, 2, 0, 3, 6};

        // reset
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_outputs", 32'({data, last, busy, done, cfg_err}), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // ramp up, wrap past max; a start in the done cycle must be ignored
        for (int i = 0; i < 6; i++) push(t1[i], i == 5);
        start_run(0, 0, 10, 3, 6, 1'b1);
        wait_done(0, 1'b1);

        // ramp down with ready toggling
        push(9, 0); push(5, 0); push(9, 0); push(5, 1);
        start_run(1, 2, 9, 4, 4, 1'b1);
        wait_done(1, 1'b0);

        // triangle, random backpressure
        for (int i = 0; i < 9; i++) push(t3[i], i == 8);
        start_run(2, 0, 8, 3, 9, 1'b1);
        wait_done(2, 1'b0);

        // start during a run is ignored
        push(1, 0); push(3, 0); push(5, 0); push(7, 0); push(1, 1);
        start_run(0, 1, 7, 2, 5, 1'b1);
        tick();
        cfg_mode = 2'd1; cfg_min = DW'(10); cfg_max = DW'(5); cfg_step = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        check("mid_run_start_no_err", 32'(cfg_err), 32'd0);
        wait_done(0, 1'b0);

        // constant mode with step 0, and triangle with min == max
        push(7, 0); push(7, 0); push(7, 1);
        start_run(3, 7, 9, 0, 3, 1'b1);
        wait_done(2, 1'b0);
        push(5, 0); push(5, 0); push(5, 1);
        start_run(2, 5, 5, 2, 3, 1'b1);
        wait_done(0, 1'b0);

        // rejected configurations
        start_run(0, 10, 5, 1, 4, 1'b0);
        @(negedge clk);
        check("cfg_err_pulse_end", 32'(cfg_err), 32'd0);
        check("rejected_no_valid", 32'(valid), 32'd0);
        start_run(2, 0, 5, 0, 4, 1'b0);

        // continuous run stopped while the beat is held
        last_seen = 1'b0;
        ready = 1'b0;
        push(0, 0); push(3, 0); push(6, 0); push(9, 0);
        start_run(0, 0, 10, 3, 0, 1'b1);
        tick(); ready = 1'b1;
        tick(); tick(); tick(); ready = 1'b0;
        tick(); stop = 1'b1;
        tick(); stop = 1'b0;
        @(negedge clk);
        check("stop_holds_beat", 32'({valid, data}), 32'({1'b1, DW'(9)}));
        tick(); ready = 1'b1;
        wait_done(0, 1'b0);
        check("continuous_no_last", 32'(last_seen), 32'd0);

        // asynchronous reset with a pending beat
        ready = 1'b0;
        start_run(0, 0, 100, 1, 0, 1'b1);
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        check("midrun_rst_valid", 32'(valid), 32'd0);
        check("midrun_rst_outputs", 32'({data, last, busy, done, cfg_err}), 32'd0);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        ready = 1'b1;
        push(5, 0); push(6, 1);
        start_run(0, 5, 20, 1, 2, 1'b1);
        wait_done(0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // bound on total run time
    initial begin
        #500000;
        check("global_timeout", 32'd0, 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
